// File: rtl/axi_chan_fifo_if.sv
// Handshake bundle for one buffered AXI channel: packed {valid,payload} input
// side and split valid/ready/payload output side, plus the per-beat sideband.
// Latency/backpressure: none of its own; carries S_READY and M_READY unchanged.
//
// Signals:
//   S_DATA  [DATA_W:0]   producer -> FIFO, MSB is the beat valid
//   S_USER  [USER_W-1:0] producer -> FIFO, sideband sampled with S_DATA
//   S_READY              FIFO -> producer
//   M_VALID              FIFO -> consumer
//   M_DATA  [DATA_W-1:0] FIFO -> consumer
//   M_USER  [USER_W-1:0] FIFO -> consumer
//   M_READY              consumer -> FIFO
// Modports: slave = the FIFO itself, master = the environment around it.
interface axi_chan_fifo_if #(
  parameter int DATA_W = 32,
  parameter int USER_W = 1
);
  logic [DATA_W:0]   S_DATA;
  logic [USER_W-1:0] S_USER;
  logic              S_READY;
  logic              M_VALID;
  logic [DATA_W-1:0] M_DATA;
  logic [USER_W-1:0] M_USER;
  logic              M_READY;

  modport slave (
    input  S_DATA, S_USER, M_READY,
    output S_READY, M_VALID, M_DATA, M_USER
  );

  modport master (
    output S_DATA, S_USER, M_READY,
    input  S_READY, M_VALID, M_DATA, M_USER
  );
endinterface

// File: rtl/axi_chan_fifo.sv
// DEPTH-entry first-word-fall-through FIFO for one AXI channel with sideband.
// Latency: 1 cycle from push to M_VALID; 1 beat/cycle sustained throughput.
// Backpressure: S_READY depends only on registered COUNT (low when full, or in reset).
//
// Ports:
//   IP_CLK     in   single clock, rising edge
//   IP_ARESET  in   asynchronous, active-high reset
//   bus        if   axi_chan_fifo_if.slave (S_DATA/S_USER/S_READY in, M_* out)
//   COUNT      out  entries currently held, 0..DEPTH
//   STALL_CNT  out  saturating count of cycles with M_VALID && !M_READY
//
// Build option: define AXI_CHAN_FIFO_STALL_CNT_EN to build the stall counter;
// without it STALL_CNT is tied to zero and the port list stays the same.
module axi_chan_fifo #(
  parameter  int DATA_W = 32,
  parameter  int USER_W = 1,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic             IP_CLK,
  input  logic             IP_ARESET,
  axi_chan_fifo_if.slave   bus,
  output logic [CNT_W-1:0] COUNT,
  output logic [31:0]      STALL_CNT
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Storage and pointers. Pointers are exactly log2(DEPTH) wide, so the
  // DEPTH-1 -> 0 wrap is plain binary overflow.
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [USER_W-1:0] user_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  logic              in_vld;
  logic [DATA_W-1:0] in_dat;
  logic              s_ready;
  logic              m_valid;
  logic              push;
  logic              pop;

  assign in_vld = bus.S_DATA[DATA_W];
  assign in_dat = bus.S_DATA[DATA_W-1:0];

  // Ready is held low during reset so nothing can be counted as accepted
  // while state is being discarded. It never looks at M_READY: a full FIFO
  // refuses input even if the head is leaving in the same cycle.
  assign s_ready = (count_q != FULL_CNT) && !IP_ARESET;
  assign m_valid = (count_q != '0);

  assign push = in_vld && s_ready;
  assign pop  = m_valid && bus.M_READY;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge IP_CLK or posedge IP_ARESET) begin
    if (IP_ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The array is cleared on reset so the fall-through output reads zero
  // while empty after reset instead of stale payload.
  always_ff @(posedge IP_CLK or posedge IP_ARESET) begin
    if (IP_ARESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        user_q[i] <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= in_dat;
      user_q[wr_ptr_q] <= bus.S_USER;
    end
  end

  // Fall-through head: the entry at rd_ptr is always on the output, so a
  // beat written at edge n is presented right after that edge.
  assign bus.S_READY = s_ready;
  assign bus.M_VALID = m_valid;
  assign bus.M_DATA  = data_q[rd_ptr_q];
  assign bus.M_USER  = user_q[rd_ptr_q];
  assign COUNT       = count_q;

`ifdef AXI_CHAN_FIFO_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Counts cycles where a beat is offered but refused; sticks at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (m_valid && !bus.M_READY && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge IP_CLK or posedge IP_ARESET) begin
    if (IP_ARESET) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign STALL_CNT = stall_q;
`else
  assign STALL_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_axi_chan_fifo.sv
// Self-checking bench for axi_chan_fifo (DEPTH=4, DATA_W=32, USER_W=1).
// A queue model tracks what the FIFO must hold; every stepped cycle the DUT
// outputs are compared with it, plus literal checks for the directed cases.
module tb_axi_chan_fifo;
  localparam int DW    = 32;
  localparam int UW    = 1;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  count;
  logic [31:0] stall;

  always #5 clk = ~clk;

  axi_chan_fifo_if #(.DATA_W(DW), .USER_W(UW)) bus ();

  axi_chan_fifo #(.DATA_W(DW), .USER_W(UW), .DEPTH(DEPTH)) dut (
    .IP_CLK    (clk),
    .IP_ARESET (rst),
    .bus       (bus),
    .COUNT     (count),
    .STALL_CNT (stall)
  );

  int total = 0;
  int bad   = 0;

  logic [DW+UW-1:0] mq [$];   // model contents, {user, data}, head at [0]
  longint           stall_m;  // model stall counter
  logic [DW-1:0]    got [$];  // payloads the DUT delivered on pops

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    chk("s_ready", 64'(bus.S_READY), 64'(mq.size() != DEPTH));
    chk("m_valid", 64'(bus.M_VALID), 64'(mq.size() != 0));
    chk("count", 64'(count), 64'(mq.size()));
    if (mq.size() != 0) begin
      chk("m_data", 64'(bus.M_DATA), 64'(mq[0][DW-1:0]));
      chk("m_user", 64'(bus.M_USER), 64'(mq[0][DW]));
    end
`ifdef AXI_CHAN_FIFO_STALL_CNT_EN
    chk("stall_cnt", 64'(stall), 64'(stall_m));
`else
    chk("stall_cnt_off", 64'(stall), 64'd0);
`endif
  endtask

  // One clock cycle: drive inputs (called just after a negedge), advance the
  // model across the posedge, then check at the following negedge.
  task automatic step(input logic sv, input logic [DW-1:0] d, input logic [UW-1:0] u,
                      input logic mr, output bit acc);
    bit push;
    bit pop;
    logic [DW-1:0] dd;
    dd = sv ? d : DW'($urandom());
    bus.S_DATA  = {sv, dd};
    bus.S_USER  = u;
    bus.M_READY = mr;
    push = sv && (mq.size() != DEPTH);
    pop  = (mq.size() != 0) && mr;
    if (pop) got.push_back(bus.M_DATA);
    if ((mq.size() != 0) && !mr && (stall_m != 64'hFFFF_FFFF)) stall_m++;
    acc = push;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({u, d});
    @(negedge clk);
    check_model();
  endtask

  task automatic model_reset();
    mq.delete();
    stall_m = 0;
  endtask

  // Assert reset between edges, check outputs without any clock, release.
  task automatic async_reset_check(input string nm);
    #2 rst = 1'b1;
    #1;
    chk({nm, "_m_valid"}, 64'(bus.M_VALID), 64'd0);
    chk({nm, "_count"}, 64'(count), 64'd0);
    chk({nm, "_s_ready"}, 64'(bus.S_READY), 64'd0);
    chk({nm, "_m_data"}, 64'(bus.M_DATA), 64'd0);
    chk({nm, "_stall"}, 64'(stall), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.S_DATA  = '0;
    bus.M_READY = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_ready_after"}, 64'(bus.S_READY), 64'd1);
    check_model();
  endtask

  initial begin
    bit acc;
    logic [31:0] nxt;
    bus.S_DATA  = '0;
    bus.S_USER  = '0;
    bus.M_READY = 1'b0;
    stall_m     = 0;

    // Reset state while reset is held
    #2;
    chk("rst_s_ready", 64'(bus.S_READY), 64'd0);
    chk("rst_m_valid", 64'(bus.M_VALID), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_m_data", 64'(bus.M_DATA), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rel_s_ready", 64'(bus.S_READY), 64'd1);
    chk("rel_m_valid", 64'(bus.M_VALID), 64'd0);
    chk("rel_count", 64'(count), 64'd0);
    chk("rel_m_data", 64'(bus.M_DATA), 64'd0);
    check_model();

    // Single beat
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, acc);
    chk("single_acc", 64'(acc), 64'd1);
    chk("single_m_valid", 64'(bus.M_VALID), 64'd1);
    chk("single_m_data", 64'(bus.M_DATA), 64'hDEADBEEF);
    chk("single_m_user", 64'(bus.M_USER), 64'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1, acc);
    chk("single_count0", 64'(count), 64'd0);
    chk("single_got", 64'(got[got.size()-1]), 64'hDEADBEEF);

    // Fill to full under backpressure; 5th beat refused
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 32'(i), 1'b0, 1'b0, acc);
      chk("fill_acc", 64'(acc), 64'(i <= 4));
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_s_ready", 64'(bus.S_READY), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", 64'(bus.M_DATA), 64'(i));
      step(1'b0, 32'h0, 1'b0, 1'b1, acc);
      if (i == 1) chk("ready_after_pop", 64'(bus.S_READY), 64'd1);
    end
    chk("drain_count", 64'(count), 64'd0);

    // Streaming 0..99 with M_READY held high, then random handshakes
    got.delete();
    nxt = 0;
    for (int c = 0; c < 100; c++) begin
      step(1'b1, nxt, UW'(nxt[0]), 1'b1, acc);
      if (acc) nxt++;
    end
    chk("stream_pushed", 64'(nxt), 64'd100);
    chk("stream_popped", 64'(got.size()), 64'd99);
    for (int c = 0; c < 2000 && nxt < 200; c++) begin
      step(1'($urandom_range(0, 1)), nxt, UW'(nxt[0]), 1'($urandom_range(0, 1)), acc);
      if (acc) nxt++;
    end
    for (int c = 0; c < 20 && mq.size() != 0; c++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1, acc);
    end
    chk("stream_total", 64'(got.size()), 64'd200);
    for (int i = 0; i < got.size(); i++) begin
      chk("stream_order", 64'(got[i]), 64'(i));
    end

    // Simultaneous push/pop at COUNT=2
    step(1'b1, 32'hA0, 1'b0, 1'b0, acc);
    step(1'b1, 32'hB1, 1'b1, 1'b0, acc);
    chk("pp_count_pre", 64'(count), 64'd2);
    chk("pp_head_pre", 64'(bus.M_DATA), 64'hA0);
    step(1'b1, 32'hC2, 1'b0, 1'b1, acc);
    chk("pp_count", 64'(count), 64'd2);
    chk("pp_head", 64'(bus.M_DATA), 64'hB1);
    chk("pp_user", 64'(bus.M_USER), 64'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1, acc);
    chk("pp_next", 64'(bus.M_DATA), 64'hC2);
    step(1'b0, 32'h0, 1'b0, 1'b1, acc);
    chk("pp_empty", 64'(count), 64'd0);

    // Async reset mid-burst with three beats held
    for (int i = 0; i < 3; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0, acc);
    chk("burst_count3", 64'(count), 64'd3);
    async_reset_check("midburst");

    // Stall counter: one beat held for 10 refused cycles, then reset
    step(1'b1, 32'd77, 1'b0, 1'b0, acc);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b0, acc);
`ifdef AXI_CHAN_FIFO_STALL_CNT_EN
    chk("stall_10", 64'(stall), 64'd10);
`else
    chk("stall_off_10", 64'(stall), 64'd0);
`endif
    async_reset_check("stall_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
